// File: rtl/cpu_loader_pkg.sv
// Shared types, widths and helpers for the CPU memory loader.
package cpu_loader_pkg;

  localparam int unsigned IMEM_WORDS_DEF = 128;
  localparam int unsigned DMEM_WORDS_DEF = 128;
  localparam int unsigned CNT_W_DEF      = 16;
  localparam int unsigned IDX_W          = 8;
  localparam int unsigned ADDR_W         = 64;
  localparam int unsigned IWORD_W        = 32;
  localparam int unsigned DWORD_W        = 64;
  localparam int unsigned IMEM_STRIDE    = 4;
  localparam int unsigned DMEM_STRIDE    = 8;
  localparam int unsigned IMEM_SHIFT     = $clog2(IMEM_STRIDE);
  localparam int unsigned DMEM_SHIFT     = $clog2(DMEM_STRIDE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_I,
    S_LOAD_DLO,
    S_LOAD_DHI,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_OUT,
    S_FIN
  } state_t;

  // Limit a requested word count to the memory depth.
  function automatic logic [IDX_W-1:0] clamp_cnt(input logic [IDX_W-1:0] n,
                                                 input int unsigned max_words);
    if (32'(n) > max_words) return IDX_W'(max_words);
    return n;
  endfunction

  // First non-empty phase among dmem preload, run and dump; FIN if all are empty.
  function automatic state_t next_phase(input logic has_dload, input logic has_run,
                                        input logic has_dump);
    if (has_dload) return S_LOAD_DLO;
    if (has_run)   return S_RUN;
    if (has_dump)  return S_DUMP_RD;
    return S_FIN;
  endfunction

endpackage

// File: rtl/reg_arstn_en.sv
// Enabled register with asynchronous active-low clear.
module reg_arstn_en #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  // Capture i_d when enabled, otherwise hold.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)   o_q <= '0;
    else if (i_en) o_q <= i_d;
  end

endmodule

// File: rtl/cpu_mem_loader.sv
// Host-side loader: streams imem/dmem contents in, runs the CPU for a set
// number of cycles, then streams a block of dmem back out.
module cpu_mem_loader
  import cpu_loader_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEF,
  parameter int unsigned DMEM_WORDS = DMEM_WORDS_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               start,
  input  logic [IDX_W-1:0]   n_imem,
  input  logic [IDX_W-1:0]   n_dload,
  input  logic [IDX_W-1:0]   n_dump,
  input  logic [CNT_W-1:0]   run_cycles,
  output logic               busy,
  output logic               done,
  input  logic               s_valid,
  input  logic [IWORD_W-1:0] s_data,
  output logic               s_ready,
  output logic               m_valid,
  output logic [DWORD_W-1:0] m_data,
  input  logic               m_ready,
  output logic               enable,
  output logic [ADDR_W-1:0]  addr_ext,
  output logic               wen_ext,
  output logic               ren_ext,
  output logic [IWORD_W-1:0] wdata_ext,
  output logic [ADDR_W-1:0]  addr_ext_2,
  output logic               wen_ext_2,
  output logic               ren_ext_2,
  output logic [DWORD_W-1:0] wdata_ext_2,
  input  logic [DWORD_W-1:0] rdata_ext_2
);

  state_t               r_state, w_nxt_state;
  logic [IDX_W-1:0]     r_idx, w_nxt_idx;
  logic [IDX_W-1:0]     r_n_imem, r_n_dload, r_n_dump;
  logic [IDX_W-1:0]     w_ni_in, w_nd_in, w_nm_in;
  logic [CNT_W-1:0]     r_run_cycles, r_run_cnt, w_nxt_run_cnt;
  logic [IWORD_W-1:0]   r_lo, w_nxt_lo;
  logic                 w_latch, w_s_xfer, w_cap;
  logic                 r_busy, r_done, r_s_ready, r_m_valid, r_enable;
  logic                 r_wen, r_wen2, r_ren2;
  logic [ADDR_W-1:0]    r_addr, r_addr2;
  logic [IWORD_W-1:0]   r_wdata;
  logic [DWORD_W-1:0]   r_wdata2;
  logic                 w_nxt_wen, w_nxt_wen2, w_nxt_ren2, w_nxt_m_valid, w_nxt_enable;
  logic [ADDR_W-1:0]    w_nxt_addr, w_nxt_addr2;
  logic [IWORD_W-1:0]   w_nxt_wdata;
  logic [DWORD_W-1:0]   w_nxt_wdata2;

  assign w_ni_in  = clamp_cnt(n_imem, IMEM_WORDS);
  assign w_nd_in  = clamp_cnt(n_dload, DMEM_WORDS);
  assign w_nm_in  = clamp_cnt(n_dump, DMEM_WORDS);
  assign w_s_xfer = s_valid & r_s_ready;

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= S_IDLE;
    else         r_state <= w_nxt_state;
  end

  // Next state, counters and next values of every registered strobe.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_idx     = r_idx;
    w_nxt_run_cnt = r_run_cnt;
    w_nxt_lo      = r_lo;
    w_latch       = 1'b0;
    w_cap         = 1'b0;
    w_nxt_wen     = 1'b0;
    w_nxt_addr    = '0;
    w_nxt_wdata   = '0;
    w_nxt_wen2    = 1'b0;
    w_nxt_ren2    = 1'b0;
    w_nxt_addr2   = '0;
    w_nxt_wdata2  = '0;
    w_nxt_m_valid = 1'b0;
    w_nxt_enable  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_latch       = 1'b1;
          w_nxt_idx     = '0;
          w_nxt_run_cnt = '0;
          w_nxt_state   = (w_ni_in != '0) ? S_LOAD_I :
                          next_phase(w_nd_in != '0, run_cycles != '0, w_nm_in != '0);
        end
      end
      S_LOAD_I: begin
        if (w_s_xfer) begin
          w_nxt_wen   = 1'b1;
          w_nxt_addr  = ADDR_W'(r_idx) << IMEM_SHIFT;
          w_nxt_wdata = s_data;
          if (r_idx == r_n_imem - IDX_W'(1)) begin
            w_nxt_idx   = '0;
            w_nxt_state = next_phase(r_n_dload != '0, r_run_cycles != '0, r_n_dump != '0);
          end else begin
            w_nxt_idx = r_idx + IDX_W'(1);
          end
        end
      end
      S_LOAD_DLO: begin
        if (w_s_xfer) begin
          w_nxt_lo    = s_data;
          w_nxt_state = S_LOAD_DHI;
        end
      end
      S_LOAD_DHI: begin
        if (w_s_xfer) begin
          w_nxt_wen2   = 1'b1;
          w_nxt_addr2  = ADDR_W'(r_idx) << DMEM_SHIFT;
          w_nxt_wdata2 = {s_data, r_lo};
          if (r_idx == r_n_dload - IDX_W'(1)) begin
            w_nxt_idx   = '0;
            w_nxt_state = next_phase(1'b0, r_run_cycles != '0, r_n_dump != '0);
          end else begin
            w_nxt_idx   = r_idx + IDX_W'(1);
            w_nxt_state = S_LOAD_DLO;
          end
        end
      end
      // First RUN cycle lets a trailing write pulse drain before enable rises.
      S_RUN: begin
        if (r_run_cnt == r_run_cycles) begin
          w_nxt_idx   = '0;
          w_nxt_state = next_phase(1'b0, 1'b0, r_n_dump != '0);
        end else begin
          w_nxt_enable  = 1'b1;
          w_nxt_run_cnt = r_run_cnt + CNT_W'(1);
        end
      end
      // One idle cycle keeps the read off the final preload write, then one read strobe.
      S_DUMP_RD: begin
        if (r_ren2) begin
          w_nxt_state = S_DUMP_OUT;
        end else begin
          w_nxt_ren2  = 1'b1;
          w_nxt_addr2 = ADDR_W'(r_idx) << DMEM_SHIFT;
        end
      end
      S_DUMP_OUT: begin
        if (!r_m_valid) begin
          w_cap         = 1'b1;
          w_nxt_m_valid = 1'b1;
        end else if (m_ready) begin
          if (r_idx == r_n_dump - IDX_W'(1)) begin
            w_nxt_state = S_FIN;
          end else begin
            w_nxt_idx   = r_idx + IDX_W'(1);
            w_nxt_state = S_DUMP_RD;
          end
        end else begin
          w_nxt_m_valid = 1'b1;
        end
      end
      S_FIN:   w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Session parameters, counters and registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_n_imem     <= '0;
      r_n_dload    <= '0;
      r_n_dump     <= '0;
      r_run_cycles <= '0;
      r_idx        <= '0;
      r_run_cnt    <= '0;
      r_lo         <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_s_ready    <= 1'b0;
      r_m_valid    <= 1'b0;
      r_enable     <= 1'b0;
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wen2       <= 1'b0;
      r_ren2       <= 1'b0;
      r_addr2      <= '0;
      r_wdata2     <= '0;
    end else begin
      if (w_latch) begin
        r_n_imem     <= w_ni_in;
        r_n_dload    <= w_nd_in;
        r_n_dump     <= w_nm_in;
        r_run_cycles <= run_cycles;
      end
      r_idx     <= w_nxt_idx;
      r_run_cnt <= w_nxt_run_cnt;
      r_lo      <= w_nxt_lo;
      r_busy    <= (w_nxt_state != S_IDLE);
      r_done    <= (w_nxt_state == S_FIN);
      r_s_ready <= (w_nxt_state == S_LOAD_I) || (w_nxt_state == S_LOAD_DLO) ||
                   (w_nxt_state == S_LOAD_DHI);
      r_m_valid <= w_nxt_m_valid;
      r_enable  <= w_nxt_enable;
      r_wen     <= w_nxt_wen;
      r_addr    <= w_nxt_addr;
      r_wdata   <= w_nxt_wdata;
      r_wen2    <= w_nxt_wen2;
      r_ren2    <= w_nxt_ren2;
      r_addr2   <= w_nxt_addr2;
      r_wdata2  <= w_nxt_wdata2;
    end
  end

  // Dump word holds from capture until the next capture.
  reg_arstn_en #(.W(DWORD_W)) u_m_data (
    .clk    (clk),
    .arst_n (arst_n),
    .i_en   (w_cap),
    .i_d    (rdata_ext_2),
    .o_q    (m_data)
  );

  assign busy        = r_busy;
  assign done        = r_done;
  assign s_ready     = r_s_ready;
  assign m_valid     = r_m_valid;
  assign enable      = r_enable;
  assign addr_ext    = r_addr;
  assign wen_ext     = r_wen;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = r_wdata;
  assign addr_ext_2  = r_addr2;
  assign wen_ext_2   = r_wen2;
  assign ren_ext_2   = r_ren2;
  assign wdata_ext_2 = r_wdata2;

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Directed bench for cpu_mem_loader with behavioural imem/dmem models.
module tb_cpu_mem_loader;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  n_imem = '0, n_dload = '0, n_dump = '0;
  logic [15:0] run_cycles = '0;
  logic        busy, done, s_ready, m_valid, enable;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        m_ready = 1'b0;
  logic [63:0] m_data;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0] wdata_ext;
  logic [63:0] rdata_ext_2 = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] imem [128];
  logic [63:0] dmem [128];

  int          n_iw = 0, n_dw = 0, n_en = 0, n_overlap = 0, n_done = 0;
  int          iw_streak = 0, iw_best = 0, en_streak = 0, en_last_run = 0;
  logic [63:0] last_iaddr = '0, last_daddr = '0, last_dwdata = '0;
  int          base_iw, base_dw, base_en, base_done;

  cpu_mem_loader dut (
    .clk(clk), .arst_n(arst_n), .start(start), .n_imem(n_imem), .n_dload(n_dload),
    .n_dump(n_dump), .run_cycles(run_cycles), .busy(busy), .done(done),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready), .enable(enable), .addr_ext(addr_ext),
    .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
  );

  always #5 clk = ~clk;

  // Synchronous CPU memories: write on strobe, read data valid one cycle after ren.
  always @(posedge clk) begin
    if (wen_ext)   imem[addr_ext[8:2]] <= wdata_ext;
    if (wen_ext_2) dmem[addr_ext_2[9:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[9:3]];
  end

  // Mid-cycle activity counters.
  always @(negedge clk) begin
    if (wen_ext) begin
      n_iw++; last_iaddr = addr_ext; iw_streak++;
      if (iw_streak > iw_best) iw_best = iw_streak;
    end else iw_streak = 0;
    if (wen_ext_2) begin n_dw++; last_daddr = addr_ext_2; last_dwdata = wdata_ext_2; end
    if (enable) begin
      n_en++; en_streak++;
      if (wen_ext || wen_ext_2 || ren_ext_2 || ren_ext) n_overlap++;
    end else if (en_streak != 0) begin
      en_last_run = en_streak; en_streak = 0;
    end
    if (done) n_done++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    base_iw = n_iw; base_dw = n_dw; base_en = n_en; base_done = n_done;
  endtask

  task automatic start_session(input logic [7:0] ni, input logic [7:0] nd,
                               input logic [7:0] nm, input logic [15:0] rc);
    @(posedge clk); #1;
    n_imem = ni; n_dload = nd; n_dump = nm; run_cycles = rc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input string tag, input logic [31:0] d);
    int t = 0;
    s_valid = 1'b1; s_data = d;
    do begin @(negedge clk); t++; end while (!s_ready && t < 200);
    check({tag, "_sready"}, s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    do begin @(negedge clk); t++; end while (!done && t < 500);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_at_done"}, busy, 1);
    @(negedge clk);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_addr_idle"}, addr_ext | addr_ext_2, 0);
  endtask

  task automatic recv_word(input string tag, input logic [63:0] exp, input int stall);
    int t = 0;
    m_ready = 1'b0;
    do begin @(negedge clk); t++; end while (!m_valid && t < 200);
    check({tag, "_valid"}, m_valid, 1);
    check({tag, "_data"}, m_data, exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, m_valid, 1);
      check({tag, "_hold_data"}, m_data, exp);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sready", s_ready, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_mdata", m_data, 0);
    check("rst_enable", enable, 0);
    check("rst_strobes", {wen_ext, ren_ext, wen_ext_2, ren_ext_2}, 0);
    check("rst_addr", addr_ext | addr_ext_2, 0);
    check("rst_wdata", {32'h0, wdata_ext} | wdata_ext_2, 0);
    arst_n = 1'b1;

    // 1: three imem words back to back
    snap();
    start_session(8'd3, 8'd0, 8'd0, 16'd0);
    check("t1_busy_after_start", busy, 1);
    send_word("t1_w0", 32'h0050_0093);
    send_word("t1_w1", 32'h00A0_0113);
    send_word("t1_w2", 32'h0020_81B3);
    wait_done("t1");
    check("t1_nwrites", 64'(n_iw - base_iw), 3);
    check("t1_consecutive", 64'(iw_best), 3);
    check("t1_last_addr", last_iaddr, 64'h8);
    check("t1_imem0", imem[0], 32'h0050_0093);
    check("t1_imem1", imem[1], 32'h00A0_0113);
    check("t1_imem2", imem[2], 32'h0020_81B3);
    check("t1_no_enable", 64'(n_en - base_en), 0);
    check("t1_one_done", 64'(n_done - base_done), 1);

    // 2: one dmem word with gapped beats
    snap();
    start_session(8'd0, 8'd1, 8'd0, 16'd0);
    send_word("t2_lo", 32'hDEAD_BEEF);
    repeat (3) @(posedge clk); #1;
    send_word("t2_hi", 32'h0123_4567);
    wait_done("t2");
    check("t2_nwrites", 64'(n_dw - base_dw), 1);
    check("t2_addr", last_daddr, 0);
    check("t2_wdata", last_dwdata, 64'h0123_4567_DEAD_BEEF);
    check("t2_dmem0", dmem[0], 64'h0123_4567_DEAD_BEEF);

    // 3: program then run for 20 cycles
    snap();
    start_session(8'd3, 8'd0, 8'd0, 16'd20);
    send_word("t3_w0", 32'h0050_0093);
    send_word("t3_w1", 32'h00A0_0113);
    send_word("t3_w2", 32'h0020_81B3);
    wait_done("t3");
    check("t3_en_cycles", 64'(n_en - base_en), 20);
    check("t3_en_contiguous", 64'(en_last_run), 20);
    check("t3_no_overlap", 64'(n_overlap), 0);
    check("t3_imem0", imem[0], 32'h0050_0093);
    check("t3_imem1", imem[1], 32'h00A0_0113);
    check("t3_imem2", imem[2], 32'h0020_81B3);

    // 4: preload two dmem words and dump them with a stall
    snap();
    start_session(8'd0, 8'd2, 8'd2, 16'd0);
    send_word("t4_lo0", 32'h1111_1111);
    send_word("t4_hi0", 32'hAAAA_AAAA);
    send_word("t4_lo1", 32'h2222_2222);
    send_word("t4_hi1", 32'hBBBB_BBBB);
    recv_word("t4_dump0", 64'hAAAA_AAAA_1111_1111, 5);
    recv_word("t4_dump1", 64'hBBBB_BBBB_2222_2222, 0);
    wait_done("t4");
    check("t4_dmem1", dmem[1], 64'hBBBB_BBBB_2222_2222);
    check("t4_no_enable", 64'(n_en - base_en), 0);

    // 5: reset in the middle of RUN, then a fresh session
    start_session(8'd0, 8'd0, 8'd0, 16'd50);
    repeat (7) @(posedge clk);
    #2;
    check("t5_enable_before", enable, 1);
    arst_n = 1'b0;
    #1;
    check("t5_enable", enable, 0);
    check("t5_busy", busy, 0);
    check("t5_strobes", {wen_ext, wen_ext_2, ren_ext_2, s_ready, m_valid}, 0);
    @(negedge clk);
    arst_n = 1'b1;
    snap();
    start_session(8'd0, 8'd1, 8'd0, 16'd0);
    send_word("t5_lo", 32'h0F0F_0F0F);
    send_word("t5_hi", 32'hF0F0_F0F0);
    wait_done("t5");
    check("t5_wdata", last_dwdata, 64'hF0F0_F0F0_0F0F_0F0F);
    check("t5_one_done", 64'(n_done - base_done), 1);

    // 6: oversized imem count clamps to 128; start while busy is ignored
    snap();
    start_session(8'd200, 8'd0, 8'd0, 16'd0);
    for (int i = 0; i < 128; i++) begin
      send_word("t6_w", 32'hC000_0000 | 32'(i));
      if (i == 10) begin
        n_imem = 8'd2; n_dload = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    wait_done("t6");
    check("t6_nwrites", 64'(n_iw - base_iw), 128);
    check("t6_last_addr", last_iaddr, 64'h1FC);
    check("t6_imem127", imem[127], 32'hC000_007F);
    check("t6_imem11", imem[11], 32'hC000_000B);
    repeat (3) @(negedge clk);
    check("t6_idle_busy", busy, 0);
    check("t6_sready", s_ready, 0);
    check("t6_one_done", 64'(n_done - base_done), 1);
    check("t6_no_dwrite", 64'(n_dw - base_dw), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
